// File: rtl/read_iq.sv
// Byte-stream to I/Q sample formatter: pops four little-endian bytes per sample,
// scales each signed 16-bit component by 2^BITS and writes the pair to both output FIFOs.
module read_iq #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned BYTE_SIZE = 8,
  parameter int unsigned BITS      = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [BYTE_SIZE-1:0] in_dout,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  input  logic                 i_out_full,
  output logic                 i_out_wr_en,
  output logic [DATA_SIZE-1:0] q_out_din,
  input  logic                 q_out_full,
  output logic                 q_out_wr_en
);

  localparam int unsigned SAMPLE_W = 2 * BYTE_SIZE;

  typedef enum logic [2:0] {
    S_ILO = 3'd0,
    S_IHI = 3'd1,
    S_QLO = 3'd2,
    S_QHI = 3'd3,
    S_WR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SAMPLE_W-1:0]   i_reg_q, i_reg_d;
  logic [SAMPLE_W-1:0]   q_reg_q, q_reg_d;
  logic [DATA_SIZE-1:0]  i_out_q, i_out_d;
  logic [DATA_SIZE-1:0]  q_out_q, q_out_d;
  logic                  wr_en;

  // Sign-extend to the datapath width, then move the integer into fixed point.
  function automatic logic [DATA_SIZE-1:0] quantize(input logic [SAMPLE_W-1:0] s);
    logic [DATA_SIZE-1:0] ext;
    ext = {{(DATA_SIZE - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    return ext << BITS;
  endfunction

  always_comb begin
    state_d  = state_q;
    i_reg_d  = i_reg_q;
    q_reg_d  = q_reg_q;
    i_out_d  = i_out_q;
    q_out_d  = q_out_q;
    in_rd_en = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_ILO: begin
        // reset_n gate keeps the pop strobe low while reset is held
        if (!in_empty && reset_n) begin
          in_rd_en                = 1'b1;
          i_reg_d[BYTE_SIZE-1:0]  = in_dout;
          state_d                 = S_IHI;
        end
      end
      S_IHI: begin
        if (!in_empty) begin
          in_rd_en                       = 1'b1;
          i_reg_d[SAMPLE_W-1:BYTE_SIZE]  = in_dout;
          state_d                        = S_QLO;
        end
      end
      S_QLO: begin
        if (!in_empty) begin
          in_rd_en                = 1'b1;
          q_reg_d[BYTE_SIZE-1:0]  = in_dout;
          state_d                 = S_QHI;
        end
      end
      S_QHI: begin
        if (!in_empty) begin
          in_rd_en                       = 1'b1;
          q_reg_d[SAMPLE_W-1:BYTE_SIZE]  = in_dout;
          i_out_d                        = quantize(i_reg_q);
          q_out_d                        = quantize({in_dout, q_reg_q[BYTE_SIZE-1:0]});
          state_d                        = S_WR;
        end
      end
      S_WR: begin
        if (!i_out_full && !q_out_full) begin
          wr_en   = 1'b1;
          state_d = S_ILO;
        end
      end
      default: state_d = S_ILO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ILO;
      i_reg_q <= '0;
      q_reg_q <= '0;
      i_out_q <= '0;
      q_out_q <= '0;
    end else begin
      state_q <= state_d;
      i_reg_q <= i_reg_d;
      q_reg_q <= q_reg_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
    end
  end

  assign i_out_din   = i_out_q;
  assign q_out_din   = q_out_q;
  assign i_out_wr_en = wr_en;
  assign q_out_wr_en = wr_en;

endmodule

// File: tb/tb_read_iq.sv
// Bench for read_iq: FIFO-level model of pops and paired writes, directed scenarios
// with literal expectations, and a randomized streaming run.
module tb_read_iq;

  logic        clock;
  logic        reset_n;
  logic [7:0]  in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] i_out_din;
  logic        i_out_full;
  logic        i_out_wr_en;
  logic [31:0] q_out_din;
  logic        q_out_full;
  logic        q_out_wr_en;

  read_iq dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .i_out_din   (i_out_din),
    .i_out_full  (i_out_full),
    .i_out_wr_en (i_out_wr_en),
    .q_out_din   (q_out_din),
    .q_out_full  (q_out_full),
    .q_out_wr_en (q_out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_pops   = 0;
  logic        starve   = 1'b0;
  logic [7:0]  in_q[$];
  logic [31:0] wl_i[$];
  logic [31:0] wl_q[$];
  int          wl_c[$];
  int          wl_s[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // Signed 16-bit value times 2^10, as a 32-bit two's complement word.
  function automatic logic [31:0] quant(input logic [7:0] hi, input logic [7:0] lo);
    shortint s;
    s = shortint'({hi, lo});
    return 32'(int'(s) * 1024);
  endfunction

  function automatic void upd_in();
    in_empty = starve || (in_q.size() == 0);
    in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
  endfunction

  // Model: pop whenever a byte is available and no pair is waiting; a completed
  // pair must be written as soon as both FIFOs have room, and nothing is popped meanwhile.
  logic        pending = 1'b0;
  logic [31:0] pend_i  = '0;
  logic [31:0] pend_q  = '0;
  int          pend_s  = 0;
  int          nb      = 0;
  int          s_start = 0;
  logic [7:0]  sb[4];

  always begin : compare
    logic pop_now, exp_rd, exp_wr;
    @(negedge clock);
    cyc++;
    pop_now = 1'b0;
    if (!reset_n) begin
      chk1("rst_rd_en", in_rd_en, 1'b0);
      chk1("rst_i_wr_en", i_out_wr_en, 1'b0);
      chk1("rst_q_wr_en", q_out_wr_en, 1'b0);
      chk32("rst_i_din", i_out_din, 32'h0);
      chk32("rst_q_din", q_out_din, 32'h0);
      nb      = 0;
      pending = 1'b0;
    end else begin
      exp_rd = !pending && !in_empty;
      exp_wr = pending && !i_out_full && !q_out_full;
      chk1("rd_en", in_rd_en, exp_rd);
      chk1("i_wr_en", i_out_wr_en, exp_wr);
      chk1("q_wr_en", q_out_wr_en, exp_wr);
      if (pending) begin
        chk32("i_din", i_out_din, pend_i);
        chk32("q_din", q_out_din, pend_q);
      end
      if (i_out_wr_en) begin
        wl_i.push_back(i_out_din);
        wl_q.push_back(q_out_din);
        wl_c.push_back(cyc);
        wl_s.push_back(pend_s);
        pending = 1'b0;
      end
      if (in_rd_en) begin
        pop_now = 1'b1;
        n_pops++;
        if (nb == 0) s_start = cyc;
        sb[nb] = in_dout;
        nb++;
        if (nb == 4) begin
          pend_i  = quant(sb[1], sb[0]);
          pend_q  = quant(sb[3], sb[2]);
          pend_s  = s_start;
          pending = 1'b1;
          nb      = 0;
        end
      end
    end
    if (pop_now) begin
      @(posedge clock);
      #1;
      if (in_q.size() != 0) void'(in_q.pop_front());
      upd_in();
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    in_q.push_back(b0);
    in_q.push_back(b1);
    in_q.push_back(b2);
    in_q.push_back(b3);
    upd_in();
  endtask

  task automatic clear_log();
    wl_i.delete();
    wl_q.delete();
    wl_c.delete();
    wl_s.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (wl_i.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk1({name, "_write_seen"}, wl_i.size() >= n, 1'b1);
  endtask

  task automatic wait_drained(input int budget, input string name);
    int k;
    k = 0;
    while (in_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk1({name, "_drained"}, in_q.size() == 0, 1'b1);
  endtask

  initial begin : stim
    int p0, c_drop;
    logic [7:0]  bytes[$];
    logic [31:0] ei[$];
    logic [31:0] eq[$];
    logic [7:0]  r0, r1, r2, r3;
    int          k;

    reset_n    = 1'b0;
    i_out_full = 1'b0;
    q_out_full = 1'b0;
    upd_in();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Basic pair, plus write latency from the first pop
    clear_log();
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    wait_writes(1, 40, "basic");
    if (wl_i.size() >= 1) begin
      chk32("basic_i", wl_i[0], 32'h0048D000);
      chk32("basic_q", wl_q[0], 32'hFEAF3400);
      chk32("basic_latency", 32'(wl_c[0] - wl_s[0]), 32'd4);
    end
    repeat (3) tick();

    // Extremes of the signed 16-bit range
    clear_log();
    push4(8'hFF, 8'h7F, 8'h00, 8'h80);
    wait_writes(1, 40, "extreme");
    if (wl_i.size() >= 1) begin
      chk32("extreme_i", wl_i[0], 32'h01FFFC00);
      chk32("extreme_q", wl_q[0], 32'hFE000000);
    end
    repeat (3) tick();

    // Starvation between the second and third byte
    clear_log();
    p0 = n_pops;
    in_q.push_back(8'h34);
    in_q.push_back(8'h12);
    upd_in();
    wait_drained(20, "starve_head");
    starve = 1'b1;
    in_q.push_back(8'hCD);
    in_q.push_back(8'hAB);
    upd_in();
    repeat (7) tick();
    starve = 1'b0;
    upd_in();
    wait_writes(1, 40, "starve");
    repeat (3) tick();
    chk32("starve_pops", 32'(n_pops - p0), 32'd4);
    chk32("starve_nwrites", 32'(wl_i.size()), 32'd1);
    if (wl_i.size() >= 1) begin
      chk32("starve_i", wl_i[0], 32'h0048D000);
      chk32("starve_q", wl_q[0], 32'hFEAF3400);
    end

    // Backpressure from the imaginary FIFO only
    clear_log();
    q_out_full = 1'b1;
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    wait_drained(20, "bp");
    repeat (10) tick();
    chk32("bp_no_write", 32'(wl_i.size()), 32'd0);
    p0 = n_pops;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (2) tick();
    chk32("bp_no_pop", 32'(n_pops - p0), 32'd0);
    c_drop     = cyc;
    q_out_full = 1'b0;
    wait_writes(1, 20, "bp");
    if (wl_i.size() >= 1) begin
      chk32("bp_write_cycle", 32'(wl_c[0]), 32'(c_drop + 1));
      chk32("bp_i", wl_i[0], 32'h0048D000);
      chk32("bp_q", wl_q[0], 32'hFEAF3400);
    end
    wait_writes(2, 40, "bp_next");
    if (wl_i.size() >= 2) begin
      chk32("bp_next_i", wl_i[1], 32'h00080400);
      chk32("bp_next_q", wl_q[1], 32'h00100C00);
    end
    repeat (3) tick();

    // Reset in the middle of a sample
    clear_log();
    in_q.push_back(8'h11);
    in_q.push_back(8'h22);
    upd_in();
    wait_drained(20, "rst");
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    wait_writes(1, 40, "rst");
    repeat (10) tick();
    chk32("rst_nwrites", 32'(wl_i.size()), 32'd1);
    if (wl_i.size() >= 1) begin
      chk32("rst_i", wl_i[0], 32'h0048D000);
      chk32("rst_q", wl_q[0], 32'hFEAF3400);
    end

    // Streaming with random empty/full toggling
    clear_log();
    bytes.delete();
    ei.delete();
    eq.delete();
    for (int n = 0; n < 1000; n++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      bytes.push_back(r0);
      bytes.push_back(r1);
      bytes.push_back(r2);
      bytes.push_back(r3);
      ei.push_back(quant(r1, r0));
      eq.push_back(quant(r3, r2));
    end
    foreach (bytes[j]) in_q.push_back(bytes[j]);
    upd_in();
    k = 0;
    while (wl_i.size() < 1000 && k < 40000) begin
      starve     = ($urandom_range(3) == 0);
      i_out_full = ($urandom_range(4) == 0);
      q_out_full = ($urandom_range(4) == 0);
      upd_in();
      tick();
      k++;
    end
    starve     = 1'b0;
    i_out_full = 1'b0;
    q_out_full = 1'b0;
    upd_in();
    repeat (5) tick();
    chk32("stream_nwrites", 32'(wl_i.size()), 32'd1000);
    chk32("stream_left", 32'(in_q.size()), 32'd0);
    for (int n = 0; n < 1000 && n < wl_i.size(); n++) begin
      chk32("stream_i", wl_i[n], ei[n]);
      chk32("stream_q", wl_q[n], eq[n]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
